// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared opcodes, access sizes, defaults and arbiter state type
//            for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DEF_M_WIDTH        = 32;
    localparam int DEF_REG_CNT        = 16;
    localparam int DEF_REG_ADDR_WIDTH = 4;
    localparam int DEF_OP_WIDTH       = 7;

    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AIUPC       = 7'b0010111;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OP_INTEGER     = 7'b0110011;

    localparam logic [2:0] MEM_ACC_8  = 3'd0;
    localparam logic [2:0] MEM_ACC_16 = 3'd1;
    localparam logic [2:0] MEM_ACC_32 = 3'd2;

    typedef enum logic [0:0] {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } arb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : Request, issue, scoreboard and writeback signals of the
//            writeback arbiter; slave = arbiter, master = surrounding pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int M_WIDTH        = DEF_M_WIDTH,
    parameter int REG_CNT        = DEF_REG_CNT,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int OP_WIDTH       = DEF_OP_WIDTH
) ();

    logic                      alu_valid;
    logic                      alu_ready;
    logic [OP_WIDTH-1:0]       alu_op;
    logic [2:0]                alu_funct3;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [M_WIDTH-1:0]        alu_val;

    logic                      lsu_valid;
    logic                      lsu_ready;
    logic [OP_WIDTH-1:0]       lsu_op;
    logic [2:0]                lsu_funct3;
    logic [REG_ADDR_WIDTH-1:0] lsu_rd;
    logic [M_WIDTH-1:0]        lsu_val;

    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic [REG_CNT-1:0]        busy;
    logic                      protocol_err;

    logic                      wb_en;
    logic [OP_WIDTH-1:0]       wb_op;
    logic [2:0]                wb_funct3;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_addr;
    logic [M_WIDTH-1:0]        wb_val;

    modport slave (
        input  alu_valid, alu_op, alu_funct3, alu_rd, alu_val,
        output alu_ready,
        input  lsu_valid, lsu_op, lsu_funct3, lsu_rd, lsu_val,
        output lsu_ready,
        input  issue_valid, issue_rd,
        output busy, protocol_err,
        output wb_en, wb_op, wb_funct3, wb_reg_addr, wb_val
    );

    modport master (
        output alu_valid, alu_op, alu_funct3, alu_rd, alu_val,
        input  alu_ready,
        output lsu_valid, lsu_op, lsu_funct3, lsu_rd, lsu_val,
        input  lsu_ready,
        output issue_valid, issue_rd,
        input  busy, protocol_err,
        input  wb_en, wb_op, wb_funct3, wb_reg_addr, wb_val
    );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter; req[0]=ALU, req[1]=LSU.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import wb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    output logic      [1:0] grant
);

    arb_state_t r_state;
    arb_state_t w_next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LAST_LSU;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        grant        = 2'b00;
        w_next_state = r_state;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Conflict: whoever was not served last goes first.
            2'b11:   grant = (r_state == LAST_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (grant[0]) begin
            w_next_state = LAST_ALU;
        end else if (grant[1]) begin
            w_next_state = LAST_LSU;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Arbitrates ALU/LSU results onto the writeback port and keeps a
//            per-register busy scoreboard. WB_ARB_STATS_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int M_WIDTH        = DEF_M_WIDTH,
    parameter int REG_CNT        = DEF_REG_CNT,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int OP_WIDTH       = DEF_OP_WIDTH
) (
    input  wire logic    clk,
    input  wire logic    rst,
    wb_arbiter_if.slave  bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]  conflict_cnt,
    output logic [31:0]  wb_cnt
`endif
);

    logic [1:0]                w_grant;
    logic                      r_wb_en;
    logic [OP_WIDTH-1:0]       r_wb_op;
    logic [2:0]                r_wb_funct3;
    logic [REG_ADDR_WIDTH-1:0] r_wb_reg_addr;
    logic [M_WIDTH-1:0]        r_wb_val;
    logic [REG_CNT-1:0]        r_busy;
    logic                      r_protocol_err;
    logic [REG_CNT-1:0]        w_set_mask;
    logic [REG_CNT-1:0]        w_clr_mask;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.lsu_valid, bus.alu_valid}),
        .grant (w_grant)
    );

    assign bus.alu_ready = w_grant[0];
    assign bus.lsu_ready = w_grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en       <= 1'b0;
            r_wb_op       <= '0;
            r_wb_funct3   <= '0;
            r_wb_reg_addr <= '0;
            r_wb_val      <= '0;
        end else begin
            r_wb_en <= |w_grant;
            if (w_grant[0]) begin
                r_wb_op       <= bus.alu_op;
                r_wb_funct3   <= bus.alu_funct3;
                r_wb_reg_addr <= bus.alu_rd;
                r_wb_val      <= bus.alu_val;
            end else if (w_grant[1]) begin
                r_wb_op       <= bus.lsu_op;
                r_wb_funct3   <= bus.lsu_funct3;
                r_wb_reg_addr <= bus.lsu_rd;
                r_wb_val      <= bus.lsu_val;
            end
        end
    end

    // Bit 0 is never set and indices beyond REG_CNT match no mask bit.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 1; i < REG_CNT; i++) begin
            w_set_mask[i] = bus.issue_valid && (bus.issue_rd == REG_ADDR_WIDTH'(i));
            w_clr_mask[i] = r_wb_en && (r_wb_reg_addr == REG_ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (|(w_set_mask & r_busy & ~w_clr_mask)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.protocol_err = r_protocol_err;
    assign bus.wb_en        = r_wb_en;
    assign bus.wb_op        = r_wb_op;
    assign bus.wb_funct3    = r_wb_funct3;
    assign bus.wb_reg_addr  = r_wb_reg_addr;
    assign bus.wb_val       = r_wb_val;

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
            wb_cnt       <= '0;
        end else begin
            if (bus.alu_valid && bus.lsu_valid && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (r_wb_en) begin
                wb_cnt <= wb_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench: vector table with expected grants/busy and
//            a writeback scoreboard queue, plus reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_pkg::*;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] lval;
        logic        iv;
        logic [3:0]  ird;
        logic        ea;
        logic        el;
        logic [15:0] eb;
        logic        ep;
    } vec_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  rd;
        logic [31:0] val;
    } wb_exp_t;

    logic clk;
    logic rst;
    int   tests  = 0;
    int   failed = 0;
    int   exp_conf = 0;
    int   exp_wb   = 0;
    wb_exp_t sb_q[$];
    wb_exp_t last;
    vec_t    vecs[20];

    wb_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [31:0] wb_cnt;
`endif

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .wb_cnt       (wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic av, logic [3:0] ard, logic [31:0] aval,
                                logic lv, logic [3:0] lrd, logic [31:0] lval,
                                logic iv, logic [3:0] ird, logic ea, logic el,
                                logic [15:0] eb, logic ep);
        vec_t v;
        v.av = av; v.ard = ard; v.aval = aval;
        v.lv = lv; v.lrd = lrd; v.lval = lval;
        v.iv = iv; v.ird = ird; v.ea = ea; v.el = el; v.eb = eb; v.ep = ep;
        return v;
    endfunction

    // Called at posedge+1: drive, check ready, cross the edge, check outputs.
    task automatic run_vec(input vec_t v, input int idx);
        wb_exp_t e;
        bus.alu_valid   = v.av;
        bus.alu_op      = OP_INTEGER;
        bus.alu_funct3  = 3'd0;
        bus.alu_rd      = v.ard;
        bus.alu_val     = v.aval;
        bus.lsu_valid   = v.lv;
        bus.lsu_op      = OP_LOAD;
        bus.lsu_funct3  = MEM_ACC_32;
        bus.lsu_rd      = v.lrd;
        bus.lsu_val     = v.lval;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        #1;
        chk($sformatf("alu_ready[%0d]", idx), {31'd0, bus.alu_ready}, {31'd0, v.ea});
        chk($sformatf("lsu_ready[%0d]", idx), {31'd0, bus.lsu_ready}, {31'd0, v.el});
        if (v.av && v.lv) exp_conf++;
        if (v.ea) begin
            e.op = OP_INTEGER; e.f3 = 3'd0; e.rd = v.ard; e.val = v.aval;
            sb_q.push_back(e);
        end else if (v.el) begin
            e.op = OP_LOAD; e.f3 = MEM_ACC_32; e.rd = v.lrd; e.val = v.lval;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("wb_en[%0d]", idx), {31'd0, bus.wb_en}, 32'd1);
            last = e;
            exp_wb++;
        end else begin
            chk($sformatf("wb_en[%0d]", idx), {31'd0, bus.wb_en}, 32'd0);
            e = last;
        end
        chk($sformatf("wb_op[%0d]", idx), {25'd0, bus.wb_op}, {25'd0, e.op});
        chk($sformatf("wb_funct3[%0d]", idx), {29'd0, bus.wb_funct3}, {29'd0, e.f3});
        chk($sformatf("wb_reg_addr[%0d]", idx), {28'd0, bus.wb_reg_addr}, {28'd0, e.rd});
        chk($sformatf("wb_val[%0d]", idx), bus.wb_val, e.val);
        chk($sformatf("busy[%0d]", idx), {16'd0, bus.busy}, {16'd0, v.eb});
        chk($sformatf("protocol_err[%0d]", idx), {31'd0, bus.protocol_err}, {31'd0, v.ep});
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 32'h11,   1, 2,  32'h22, 0, 0, 1, 0, 16'h0000, 0);
        vecs[1]  = mk(1, 1, 32'h11,   1, 2,  32'h22, 0, 0, 0, 1, 16'h0000, 0);
        vecs[2]  = mk(1, 1, 32'h11,   1, 2,  32'h22, 0, 0, 1, 0, 16'h0000, 0);
        vecs[3]  = mk(1, 1, 32'h11,   1, 2,  32'h22, 0, 0, 0, 1, 16'h0000, 0);
        vecs[4]  = mk(1, 5, 32'h1234, 0, 0,  32'h0,  0, 0, 1, 0, 16'h0000, 0);
        vecs[5]  = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0000, 0);
        vecs[6]  = mk(0, 0, 32'h0,    0, 0,  32'h0,  1, 7, 0, 0, 16'h0080, 0);
        vecs[7]  = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0080, 0);
        vecs[8]  = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0080, 0);
        vecs[9]  = mk(0, 0, 32'h0,    1, 7,  32'h77, 0, 0, 0, 1, 16'h0080, 0);
        vecs[10] = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0000, 0);
        vecs[11] = mk(0, 0, 32'h0,    1, 3,  32'h33, 1, 3, 0, 1, 16'h0008, 0);
        vecs[12] = mk(0, 0, 32'h0,    0, 0,  32'h0,  1, 3, 0, 0, 16'h0008, 0);
        vecs[13] = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0008, 0);
        vecs[14] = mk(0, 0, 32'h0,    0, 0,  32'h0,  1, 4, 0, 0, 16'h0018, 0);
        vecs[15] = mk(0, 0, 32'h0,    0, 0,  32'h0,  1, 4, 0, 0, 16'h0018, 1);
        vecs[16] = mk(0, 0, 32'h0,    0, 0,  32'h0,  1, 0, 0, 0, 16'h0018, 1);
        vecs[17] = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0018, 1);
        vecs[18] = mk(1, 9, 32'h99,   1, 10, 32'hAA, 0, 0, 1, 0, 16'h0018, 1);
        vecs[19] = mk(0, 0, 32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 16'h0018, 1);

        last = '{op: 7'd0, f3: 3'd0, rd: 4'd0, val: 32'd0};
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_op = '0; bus.alu_funct3 = '0;
        bus.alu_rd = '0; bus.alu_val = '0;
        bus.lsu_valid = 1'b0; bus.lsu_op = '0; bus.lsu_funct3 = '0;
        bus.lsu_rd = '0; bus.lsu_val = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;

        @(posedge clk);
        #1;
        chk("reset wb_en", {31'd0, bus.wb_en}, 32'd0);
        chk("reset wb_val", bus.wb_val, 32'd0);
        chk("reset wb_reg_addr", {28'd0, bus.wb_reg_addr}, 32'd0);
        chk("reset busy", {16'd0, bus.busy}, 32'd0);
        chk("reset protocol_err", {31'd0, bus.protocol_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

`ifdef WB_ARB_STATS_EN
        chk("conflict_cnt", {16'd0, conflict_cnt}, exp_conf);
        chk("wb_cnt", wb_cnt, exp_wb);
`endif

        // Sticky error only clears through reset.
        rst = 1'b1;
        #1;
        chk("rst1 busy", {16'd0, bus.busy}, 32'd0);
        chk("rst1 protocol_err", {31'd0, bus.protocol_err}, 32'd0);
        chk("rst1 wb_en", {31'd0, bus.wb_en}, 32'd0);
        #1;
        rst  = 1'b0;
        last = '{op: 7'd0, f3: 3'd0, rd: 4'd0, val: 32'd0};

        run_vec(mk(0, 0, 32'h0,  0, 0, 32'h0, 1, 4, 0, 0, 16'h0010, 0), 100);
        run_vec(mk(0, 0, 32'h0,  0, 0, 32'h0, 1, 5, 0, 0, 16'h0030, 0), 101);
        run_vec(mk(0, 0, 32'h0,  0, 0, 32'h0, 1, 6, 0, 0, 16'h0070, 0), 102);
        run_vec(mk(1, 8, 32'h88, 1, 2, 32'h2, 1, 7, 1, 0, 16'h00F0, 0), 103);

        // Reset between edges while wb_en is high and busy=0x00F0.
        #2;
        rst = 1'b1;
        #1;
        chk("rst2 busy", {16'd0, bus.busy}, 32'd0);
        chk("rst2 wb_en", {31'd0, bus.wb_en}, 32'd0);
`ifdef WB_ARB_STATS_EN
        chk("rst2 conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        chk("rst2 wb_cnt", wb_cnt, 32'd0);
`endif
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        rst  = 1'b0;
        last = '{op: 7'd0, f3: 3'd0, rd: 4'd0, val: 32'd0};
        sb_q.delete();

        run_vec(mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 16'h0000, 0), 104);
        run_vec(mk(1, 1, 32'h5A, 1, 2, 32'hA5, 0, 0, 1, 0, 16'h0000, 0), 105);
        run_vec(mk(0, 0, 32'h0,  1, 2, 32'hA5, 0, 0, 0, 1, 16'h0000, 0), 106);
        run_vec(mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 16'h0000, 0), 107);

        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
